// File: rtl/cic_interp_ctrl_pkg.sv
// cic_ctrl_pkg: shared types and constants for the CIC interpolation controller
// and the phase counter reused by decimation control.
package cic_ctrl_pkg;

  // Width of the saturating underrun counter.
  localparam int UNDERRUN_CNT_W = 16;

  // Default widths for the ratio/phase counter and for samples.
  localparam int RATIO_W_DEFAULT  = 8;
  localparam int BITWIDTH_DEFAULT = 32;

  // Controller sequencing states.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PRIME    = 2'd1,
    ST_RUN      = 2'd2,
    ST_STOPPING = 2'd3
  } ctrl_state_t;

endpackage

// File: rtl/cic_interp_ctrl_if.sv
// cic_interp_ctrl_if: upstream sample handshake (data/valid/ready).
// The sample source is the master, the controller is the slave.
interface cic_interp_ctrl_if
  import cic_ctrl_pkg::*;
#(
  parameter int BITWIDTH = BITWIDTH_DEFAULT
);

  logic [BITWIDTH-1:0] in_data;
  logic                in_valid;
  logic                in_ready;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready
  );

endinterface

// File: rtl/cic_phase_counter.sv
// cic_phase_counter: position within a rate-change period. Counts 0..i_term
// and wraps; o_wrap flags the terminal-count cycle. Shared with decimation
// control, so it carries no knowledge of the controller states.
module cic_phase_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_ena,
  input  logic [WIDTH-1:0] i_term,
  output logic [WIDTH-1:0] o_count,
  output logic             o_wrap
);

  logic [WIDTH-1:0] r_count;

  assign o_wrap  = (r_count == i_term);
  assign o_count = r_count;

  // Load clears to the start of a period; otherwise step and wrap at terminal count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= '0;
    end else if (i_ena) begin
      if (o_wrap) begin
        r_count <= '0;
      end else begin
        r_count <= r_count + WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/cic_interp_ctrl.sv
// cic_interp_ctrl: sequencer for the CIC interpolation chain.
// Buffers one upstream sample, strobes the combs once per R clocks, runs the
// integrators every clock and drives the zero-stuff select.
// Optional feature: define CIC_CTRL_UNDERRUN_CNT_EN to get a saturating
// underrun counter; otherwise o_underrun_cnt is tied to zero.
module cic_interp_ctrl
  import cic_ctrl_pkg::*;
#(
  parameter int BITWIDTH = BITWIDTH_DEFAULT,
  parameter int RATIO_W  = RATIO_W_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [RATIO_W-1:0]        i_ratio,
  input  logic                      i_start,
  input  logic                      i_stop,
  cic_interp_ctrl_if.slave          up,
  output logic                      o_comb_ena,
  output logic [BITWIDTH-1:0]       o_comb_in,
  output logic                      o_integ_ena,
  output logic                      o_pass_sel,
  output logic [RATIO_W-1:0]        o_phase,
  output logic                      o_busy,
  output logic                      o_underrun,
  output logic [UNDERRUN_CNT_W-1:0] o_underrun_cnt
);

  ctrl_state_t         r_state;
  ctrl_state_t         w_state_nxt;
  logic [RATIO_W-1:0]  r_ratio;
  logic [BITWIDTH-1:0] r_buf;
  logic                r_buf_full;
  logic                r_stop_pending;
  logic [BITWIDTH-1:0] r_comb_in;
  logic                r_pass_sel;
  logic                r_underrun;

  logic [RATIO_W-1:0]  w_phase;
  logic [RATIO_W-1:0]  w_term;
  logic                w_wrap;
  logic                w_in_ready;
  logic                w_hs;
  logic                w_accept_start;
  logic                w_comb_ena;
  logic                w_enter_phase0;
  logic                w_underrun_set;
  logic                w_cnt_load;
  logic                w_cnt_ena;

  // Ratio is nonzero whenever the counter runs, so r_ratio-1 never underflows there.
  assign w_term     = r_ratio - RATIO_W'(1);
  assign w_cnt_load = (r_state == ST_IDLE) || (r_state == ST_PRIME);
  assign w_cnt_ena  = (r_state == ST_RUN) || (r_state == ST_STOPPING);

  cic_phase_counter #(
    .WIDTH (RATIO_W)
  ) u_phase (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_cnt_load),
    .i_ena   (w_cnt_ena),
    .i_term  (w_term),
    .o_count (w_phase),
    .o_wrap  (w_wrap)
  );

  // Ready depends only on registered state so upstream sees no combinational path.
  always_comb begin
    w_in_ready = 1'b0;
    case (r_state)
      ST_PRIME: w_in_ready = 1'b1;
      ST_RUN:   w_in_ready = !r_buf_full;
      default:  w_in_ready = 1'b0;
    endcase
  end

  assign w_hs           = up.in_valid && w_in_ready;
  assign w_accept_start = (r_state == ST_IDLE) && i_start && (i_ratio != '0);
  assign w_comb_ena     = (r_state == ST_RUN) && (w_phase == '0);
  assign w_enter_phase0 = (r_state == ST_RUN) && w_wrap && (w_state_nxt == ST_RUN);
  assign w_underrun_set = w_enter_phase0 && !r_buf_full && !w_hs;

  // Next-state logic: start only from IDLE, stop only from RUN, drain to end of period.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept_start) begin
          w_state_nxt = ST_PRIME;
        end
      end
      ST_PRIME: begin
        if (w_hs) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (i_stop) begin
          w_state_nxt = ST_STOPPING;
        end
      end
      ST_STOPPING: begin
        if (r_stop_pending && w_wrap) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Ratio is captured once per start so later changes wait for the next start.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ratio <= '0;
    end else if (w_accept_start) begin
      r_ratio <= i_ratio;
    end
  end

  // Stop request remembered until the block is back in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stop_pending <= 1'b0;
    end else if ((r_state == ST_RUN) && i_stop) begin
      r_stop_pending <= 1'b1;
    end else if (w_state_nxt == ST_IDLE) begin
      r_stop_pending <= 1'b0;
    end
  end

  // One-entry buffer: filled mid-period, drained at phase 0, dropped when stopping ends.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_buf      <= '0;
      r_buf_full <= 1'b0;
    end else if (r_state == ST_RUN) begin
      if (w_enter_phase0) begin
        r_buf_full <= 1'b0;
      end else if (w_hs) begin
        r_buf      <= up.in_data;
        r_buf_full <= 1'b1;
      end
    end else if (r_state == ST_STOPPING) begin
      if (w_state_nxt == ST_IDLE) begin
        r_buf_full <= 1'b0;
      end
    end else begin
      r_buf_full <= 1'b0;
    end
  end

  // Comb input update at each strobe: buffer first, then bypass, else zero with underrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_comb_in  <= '0;
      r_underrun <= 1'b0;
    end else begin
      r_underrun <= 1'b0;
      if ((r_state == ST_PRIME) && w_hs) begin
        r_comb_in <= up.in_data;
      end else if (w_enter_phase0) begin
        if (r_buf_full) begin
          r_comb_in <= r_buf;
        end else if (w_hs) begin
          r_comb_in <= up.in_data;
        end else begin
          r_comb_in  <= '0;
          r_underrun <= 1'b1;
        end
      end
    end
  end

  // Pass comb output on the cycle after a strobe; with R=1 every running cycle passes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pass_sel <= 1'b0;
    end else begin
      r_pass_sel <= w_comb_ena ||
                    ((r_ratio == RATIO_W'(1)) && (w_state_nxt == ST_RUN));
    end
  end

`ifdef CIC_CTRL_UNDERRUN_CNT_EN
  logic [UNDERRUN_CNT_W-1:0] r_underrun_cnt;

  // Saturating underrun tally, cleared by reset or an accepted start.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_underrun_cnt <= '0;
    end else if (w_accept_start) begin
      r_underrun_cnt <= '0;
    end else if (w_underrun_set && (r_underrun_cnt != '1)) begin
      r_underrun_cnt <= r_underrun_cnt + UNDERRUN_CNT_W'(1);
    end
  end

  assign o_underrun_cnt = r_underrun_cnt;
`else
  assign o_underrun_cnt = '0;
`endif

  assign up.in_ready   = w_in_ready;
  assign o_comb_ena    = w_comb_ena;
  assign o_comb_in     = r_comb_in;
  assign o_integ_ena   = (r_state == ST_RUN) || (r_state == ST_STOPPING);
  assign o_pass_sel    = r_pass_sel;
  assign o_phase       = w_phase;
  assign o_busy        = (r_state != ST_IDLE);
  assign o_underrun    = r_underrun;

endmodule

// File: tb/tb_cic_interp_ctrl.sv
// tb_cic_interp_ctrl: directed bench for cic_interp_ctrl with a period-arithmetic
// reference model compared every cycle, plus literal spot checks.
// Honours CIC_CTRL_UNDERRUN_CNT_EN for the expected underrun count.
module tb_cic_interp_ctrl;

  localparam int BW = 32;
  localparam int RW = 8;

`ifdef CIC_CTRL_UNDERRUN_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  localparam int M_IDLE  = 0;
  localparam int M_PRIME = 1;
  localparam int M_RUN   = 2;
  localparam int M_STOP  = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [RW-1:0] inRatio;
  logic          inStart;
  logic          inStop;
  logic          combEna;
  logic [BW-1:0] combIn;
  logic          integEna;
  logic          passSel;
  logic [RW-1:0] phase;
  logic          busy;
  logic          underrun;
  logic [15:0]   underrunCnt;

  cic_interp_ctrl_if #(.BITWIDTH(BW)) upIf ();

  cic_interp_ctrl #(.BITWIDTH(BW), .RATIO_W(RW)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_ratio        (inRatio),
    .i_start        (inStart),
    .i_stop         (inStop),
    .up             (upIf.slave),
    .o_comb_ena     (combEna),
    .o_comb_in      (combIn),
    .o_integ_ena    (integEna),
    .o_pass_sel     (passSel),
    .o_phase        (phase),
    .o_busy         (busy),
    .o_underrun     (underrun),
    .o_underrun_cnt (underrunCnt)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state: mode, cycles elapsed since entering RUN, sample buffer.
  int          mMode    = M_IDLE;
  int          mR       = 1;
  int          mK       = 0;
  bit          mBufFull = 1'b0;
  logic [31:0] mBufVal  = '0;
  logic [31:0] mCombIn  = '0;
  bit          mPass    = 1'b0;
  bit          mUnder   = 1'b0;
  int          mCnt     = 0;
  bit          mLastHs  = 1'b0;
  bit          mStarted = 1'b0;
  bit          autoData = 1'b0;

  function automatic int expPhase();
    return ((mMode == M_RUN) || (mMode == M_STOP)) ? (mK % mR) : 0;
  endfunction

  function automatic bit expCombEna();
    return (mMode == M_RUN) && (expPhase() == 0);
  endfunction

  function automatic bit expInReady();
    return (mMode == M_PRIME) || ((mMode == M_RUN) && !mBufFull);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input bit start, input bit stop, input int ratio, input bit valid);
    inStart       = start;
    inStop        = stop;
    inRatio       = RW'(ratio);
    upIf.in_valid = valid;
  endtask

  // Advance to the next falling edge; a source with autoData presents the next value after each accept.
  task automatic step();
    @(negedge clk);
    if (autoData && mLastHs) begin
      upIf.in_data = upIf.in_data + 32'd1;
    end
  endtask

  // Model update at each rising edge from the inputs presented before it.
  initial begin
    forever begin
      bit curComb;
      bit hs;
      int nPh;
      int newMode;
      @(posedge clk);
      mStarted = 1'b1;
      if (rst) begin
        mMode = M_IDLE; mK = 0; mBufFull = 1'b0; mCombIn = '0;
        mPass = 1'b0; mUnder = 1'b0; mCnt = 0; mLastHs = 1'b0;
      end else begin
        curComb = expCombEna();
        hs      = upIf.in_valid && expInReady();
        mLastHs = hs;
        mUnder  = 1'b0;
        newMode = mMode;
        case (mMode)
          M_IDLE: begin
            if (inStart && (inRatio != 0)) begin
              mR = int'(inRatio); newMode = M_PRIME; mCnt = 0; mBufFull = 1'b0;
            end
          end
          M_PRIME: begin
            if (hs) begin
              newMode = M_RUN; mK = 0; mCombIn = upIf.in_data;
            end
          end
          M_RUN: begin
            nPh = (mK + 1) % mR;
            mK++;
            if (inStop) begin
              newMode = M_STOP;
              if (hs) begin mBufFull = 1'b1; mBufVal = upIf.in_data; end
            end else if (nPh == 0) begin
              if (mBufFull) begin
                mCombIn = mBufVal; mBufFull = 1'b0;
              end else if (hs) begin
                mCombIn = upIf.in_data;
              end else begin
                mCombIn = '0; mUnder = 1'b1;
                if (CNT_EN && (mCnt < 65535)) mCnt++;
              end
            end else if (hs) begin
              mBufFull = 1'b1; mBufVal = upIf.in_data;
            end
          end
          default: begin
            if ((mK % mR) == (mR - 1)) begin
              newMode = M_IDLE; mBufFull = 1'b0; mK = 0;
            end else begin
              mK++;
            end
          end
        endcase
        mPass = curComb || ((mR == 1) && (newMode == M_RUN));
        mMode = newMode;
      end
    end
  end

  // Every-cycle comparison of the DUT against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (mStarted) begin
        checkOutput("m_busy", 32'(busy), 32'(mMode != M_IDLE));
        checkOutput("m_in_ready", 32'(upIf.in_ready), 32'(expInReady()));
        checkOutput("m_integ_ena", 32'(integEna), 32'((mMode == M_RUN) || (mMode == M_STOP)));
        checkOutput("m_comb_ena", 32'(combEna), 32'(expCombEna()));
        checkOutput("m_phase", 32'(phase), 32'(expPhase()));
        checkOutput("m_pass_sel", 32'(passSel), 32'(mPass));
        checkOutput("m_underrun", 32'(underrun), 32'(mUnder));
        checkOutput("m_underrun_cnt", 32'(underrunCnt), 32'(mCnt));
        if (expCombEna()) begin
          checkOutput("m_comb_in", combIn, mCombIn);
        end
      end
    end
  end

  // Directed scenarios with hand-computed spot checks.
  initial begin
    rst = 1'b1;
    upIf.in_data = '0;
    applyStimulus(0, 0, 0, 0);
    step();
    step();
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_in_ready", 32'(upIf.in_ready), 32'd0);
    checkOutput("rst_phase", 32'(phase), 32'd0);
    checkOutput("rst_comb_in", combIn, 32'd0);
    checkOutput("rst_cnt", 32'(underrunCnt), 32'd0);

    // Start with ratio 0 is ignored, then ratio 5 primes.
    rst = 1'b0;
    applyStimulus(1, 0, 0, 0);
    step();
    checkOutput("ratio0_busy", 32'(busy), 32'd0);
    applyStimulus(1, 0, 5, 0);
    step();
    checkOutput("start5_busy", 32'(busy), 32'd1);
    checkOutput("start5_in_ready", 32'(upIf.in_ready), 32'd1);
    applyStimulus(0, 0, 0, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;

    // R=4 streaming samples 1,2,3.
    applyStimulus(1, 0, 4, 0);
    step();
    applyStimulus(0, 0, 9, 1);
    upIf.in_data = 32'd1;
    autoData = 1'b1;
    step();
    checkOutput("r4_first_comb_ena", 32'(combEna), 32'd1);
    checkOutput("r4_first_comb_in", combIn, 32'd1);
    checkOutput("r4_first_pass_sel", 32'(passSel), 32'd0);
    step();
    checkOutput("r4_pass_sel", 32'(passSel), 32'd1);
    checkOutput("r4_phase1", 32'(phase), 32'd1);
    repeat (3) step();
    checkOutput("r4_second_comb_ena", 32'(combEna), 32'd1);
    checkOutput("r4_second_comb_in", combIn, 32'd2);
    repeat (4) step();
    checkOutput("r4_third_comb_in", combIn, 32'd3);

    // Withhold samples: next strobe underruns.
    upIf.in_valid = 1'b0;
    repeat (4) step();
    checkOutput("underrun_pulse", 32'(underrun), 32'd1);
    checkOutput("underrun_comb_in", combIn, 32'd0);
    checkOutput("underrun_cnt", 32'(underrunCnt), CNT_EN ? 32'd1 : 32'd0);

    // Stop at phase 1 while a sample is accepted into the buffer.
    step();
    checkOutput("stop_phase", 32'(phase), 32'd1);
    autoData = 1'b0;
    upIf.in_data = 32'hAA;
    applyStimulus(0, 1, 9, 1);
    step();
    checkOutput("stopping_busy", 32'(busy), 32'd1);
    checkOutput("stopping_in_ready", 32'(upIf.in_ready), 32'd0);
    applyStimulus(0, 0, 9, 0);
    step();
    checkOutput("stopping_phase3", 32'(phase), 32'd3);
    checkOutput("stopping_integ", 32'(integEna), 32'd1);
    step();
    checkOutput("idle_busy", 32'(busy), 32'd0);
    checkOutput("idle_integ", 32'(integEna), 32'd0);

    // Restart: the dropped 0xAA must never reach the combs.
    applyStimulus(1, 0, 4, 0);
    step();
    checkOutput("restart_cnt", 32'(underrunCnt), 32'd0);
    applyStimulus(0, 0, 4, 1);
    upIf.in_data = 32'h55;
    step();
    checkOutput("restart_comb_in", combIn, 32'h55);
    upIf.in_valid = 1'b0;
    repeat (4) step();
    checkOutput("dropped_comb_in", combIn, 32'd0);
    checkOutput("dropped_underrun", 32'(underrun), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;

    // R=1: strobe, pass and integrate every clock, one sample per clock.
    applyStimulus(1, 0, 1, 0);
    step();
    applyStimulus(0, 0, 1, 1);
    upIf.in_data = 32'd1;
    autoData = 1'b1;
    step();
    for (int i = 0; i < 6; i++) begin
      checkOutput("r1_comb_ena", 32'(combEna), 32'd1);
      checkOutput("r1_pass_sel", 32'(passSel), 32'd1);
      checkOutput("r1_integ_ena", 32'(integEna), 32'd1);
      checkOutput("r1_comb_in", combIn, 32'(i + 1));
      step();
    end

    // Reset in the middle of RUN.
    rst = 1'b1;
    step();
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_comb_ena", 32'(combEna), 32'd0);
    checkOutput("midrst_integ", 32'(integEna), 32'd0);
    checkOutput("midrst_pass_sel", 32'(passSel), 32'd0);
    checkOutput("midrst_comb_in", combIn, 32'd0);
    checkOutput("midrst_in_ready", 32'(upIf.in_ready), 32'd0);
    checkOutput("midrst_cnt", 32'(underrunCnt), 32'd0);
    rst = 1'b0;
    autoData = 1'b0;
    upIf.in_valid = 1'b0;
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cic_interp_ctrl.md
# cic_interp_ctrl

Sequencer for the CIC interpolation chain. Accepts low-rate samples from upstream over a valid/ready handshake and buffers one sample. Once per output period of R clocks it strobes the comb stages, runs the integrator stages every clock, and drives the zero-stuff select between the comb and integrator sections. It sits between the sample source and the comb/integrator datapath. It owns all enables, so the datapath stages hold no timing logic of their own.

## Interface
- BITWIDTH, 32, sample width presented to the comb chain
- RATIO_W, 8, width of the interpolation ratio and phase counter
- clk  in  1  system clock; all logic on posedge
- rst  in  1  reset, synchronous, active-high
- ratio  in  RATIO_W  interpolation ratio R; sampled only on accepted start
- start  in  1  begin operation (honoured in IDLE only)
- stop  in  1  request graceful stop (honoured in RUN only)
- in_data  in  BITWIDTH  upstream sample
- in_valid  in  1  upstream sample valid
- in_ready  out  1  controller can accept a sample
- comb_ena  out  1  one-cycle enable to every comb stage
- comb_in  out  BITWIDTH  sample fed to the first comb stage; valid while comb_ena=1
- integ_ena  out  1  enable to every integrator stage
- pass_sel  out  1  1 = pass comb output into the integrators; 0 = insert zero
- phase  out  RATIO_W  current position in the output period, 0..R-1
- busy  out  1  high in any state other than IDLE
- underrun  out  1  one-cycle pulse: comb strobe issued with no sample available
- underrun_cnt  out  16  saturating underrun count (see Configuration)

## Operation
- Reset: state=IDLE. All outputs 0, buffer empty, stop_pending=0, underrun_cnt=0. Reset is honoured mid-operation the same way.
- States: IDLE, PRIME, RUN, STOPPING.
- IDLE, start=1, ratio≠0: latch r_q=ratio, go to PRIME. With ratio=0, start is ignored and the block stays in IDLE.
- PRIME: in_ready=1. Handshake (in_valid&in_ready at an edge) loads the sample into comb_in and enters RUN with phase=0 and comb_ena=1.
- RUN:
  - phase increments every clock and wraps R-1→0.
  - integ_ena=1 every cycle.
  - comb_ena=1 exactly in cycles with phase=0.
  - pass_sel=1 exactly in the cycle after a comb_ena cycle; for r_q=1, pass_sel=1 every cycle.
- One-entry buffer: in_ready=!buf_full.
  - On the edge entering phase 0, comb_in takes the buffer contents and the buffer empties.
  - If the buffer is empty but a handshake occurs on that same edge, the incoming sample bypasses the buffer straight into comb_in. This is not an underrun.
  - If the buffer is empty and there is no handshake, comb_in=0 and underrun pulses in that phase-0 cycle.
- stop=1 in RUN sets stop_pending and moves to STOPPING.
  - STOPPING: in_ready=0, integrators keep running, and no further comb_ena is issued. At phase=R-1, go to IDLE and discard the buffer.
  - stop in other states is ignored. start outside IDLE is ignored.
- ratio changes after start have no effect until the next start.
- Arithmetic: phase compares against r_q-1 with a RATIO_W-bit unsigned compare; there is no wider arithmetic.

## Timing
- start at edge T → PRIME, busy=1, in_ready=1 in cycle T+1.
- Handshake at edge A → comb_ena=1, phase=0 in cycle A+1. pass_sel=1 in cycle A+2. Next comb_ena in cycle A+1+R.
- All outputs are registered; none depend combinationally on in_valid, start, or stop.
- Steady-state throughput: one sample per R clocks.
- Entering IDLE from STOPPING: integ_ena=0, busy=0 in the first IDLE cycle.

## Configuration
- CIC_CTRL_UNDERRUN_CNT_EN defined: underrun_cnt increments on each underrun pulse, saturates at 16'hFFFF, and clears only on rst or an accepted start.
- Not defined: underrun_cnt is tied to 0. The underrun pulse is still generated.

## Structure
- Package cic_ctrl_pkg holds:
  - state enum (IDLE, PRIME, RUN, STOPPING)
  - UNDERRUN_CNT_W=16
  - default RATIO_W
- Sub-module cic_phase_counter: load, enable, terminal count r_q-1, wrap flag. Reused by later decimation control.

## Test plan
- R=4, in_valid held high → comb_ena every 4th cycle, integ_ena continuous, pass_sel one cycle after each comb_ena, comb_in follows the input sequence 1,2,3…, no underrun.
- R=4, samples withheld after the first → underrun pulse at the next phase 0 with comb_in=0. underrun_cnt=1 with the macro; underrun_cnt=0 without it.
- R=1 → comb_ena, pass_sel, and integ_ena all high every cycle; in_ready paces one sample per clock.
- start with ratio=0 → stays in IDLE, busy=0. Then start with ratio=5 → PRIME on the next cycle.
- stop at phase 1 with R=4 → no further comb_ena. IDLE after the phase=3 cycle, and a buffered sample is dropped.
- rst asserted mid-RUN → next cycle all outputs 0, state IDLE, underrun_cnt=0.
